wt_dcache_mem_responder: RTL and testbench
==========================================

WT_DCACHE_MEM_RESPONDER -- requirements
Module: wt_dcache_mem_responder

Interface
REQ-001 Parameters SHALL be:
- CVA6Cfg, default config_pkg::cva6_cfg_empty, core configuration.
- dcache_req_t, default logic, D$ request struct.
- dcache_rtrn_t, default logic, D$ return struct.
- Latency, default 4, minimum accept-to-return cycles (range 1..15).
- QueueDepth, default 4, outstanding requests (power of 2, at least 2).
- MemLines, default 256, backing-store lines (power of 2).
REQ-002 Ports SHALL be:
- clk_i  in  1  single clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- data_req_i  in  1  request valid, held until acked.
- data_ack_o  out  1  request accepted this cycle.
- data_i  in  dcache_req_t  request payload.
- rtrn_vld_o  out  1  return valid, single-cycle, no backpressure.
- rtrn_o  out  dcache_rtrn_t  return payload.
- err_o  out  1  sticky error flag.

Function
REQ-003 data_ack_o SHALL equal data_req_i && (!full || pop_this_cycle); the request is captured on that same edge.
REQ-004 Backing store access SHALL happen at accept time, in acceptance order; read data is stored in the queue entry.
REQ-005 Address decode SHALL use line index paddr[DCACHE_OFFSET_WIDTH +: log2(MemLines)], with upper bits ignored.
REQ-006 DCACHE_LOAD_REQ SHALL return the full line at the index with rtype DCACHE_LOAD_ACK, independent of size and nc.
REQ-007 DCACHE_STORE_REQ SHALL write 2^size bytes starting at paddr byte offset within the line, taking each byte from the same lane of data; it returns DCACHE_STORE_ACK with data zero.
REQ-008 A store with size 3'b111 or a misaligned size/offset SHALL write nothing, still return STORE_ACK, and set err_o.
REQ-009 DCACHE_ATOMIC_REQ (size 010 or 011) SHALL return the old operand zero-extended in rtrn_o.data[XLEN-1:0] with rtype DCACHE_ATOMIC_ACK.
- AMO_SWAP writes data.
- AMO_ADD writes old+data, truncated to the operand width.
- AMO_LR makes no write.
- AMO_SC writes data and returns 0.
- Any other amo_op makes no write and sets err_o.
REQ-010 An unknown rtype SHALL be acked and dropped with no return, and SHALL set err_o.
REQ-011 rtrn_o.tid SHALL echo the request tid; rtrn_o.inv and rtrn_o.user SHALL be zero.
REQ-012 A request accepted in cycle N SHALL return no earlier than cycle N+Latency.
- Returns are strictly in order, at most one per cycle.
- Each entry holds a down-counter loaded with Latency-1 at accept, decremented each cycle, saturating at 0.
- The head pops in the cycle its counter is 0.
REQ-013 full SHALL be count==QueueDepth.
- Push and pop in the same cycle when full is legal, and count is unchanged.
- Read and write pointers wrap modulo QueueDepth.
REQ-014 When a load follows a store to the same line, the load SHALL observe the store data.

Reset
REQ-015 While rst_i is high, the block SHALL drive data_ack_o=0, rtrn_vld_o=0, rtrn_o='0 and err_o=0.
REQ-016 Reset SHALL clear the queue, pointers, counters and err_o.
REQ-017 Reset mid-operation SHALL drop in-flight returns and SHALL NOT clear backing-store contents.

Structure
REQ-018 The size-to-byte-mask function and the AMO compute function SHALL live in wt_cache_pkg.
REQ-019 The existing dcache_out_t and dcache_in_t enums from wt_cache_pkg SHALL be reused, with no new rtype encodings.
REQ-020 One sub-module, wt_mem_resp_queue, SHALL hold entries, countdowns and pointers.
REQ-021 An elaboration-time check SHALL reject Latency<1 and non-power-of-2 QueueDepth or MemLines.

Verification
REQ-022 Store paddr 0x40, size 011, data 0xDEADBEEF_CAFEF00D, tid 3, then load paddr 0x40 tid 5.
- Expected: STORE_ACK tid 3 at N+4.
- Expected: LOAD_ACK tid 5 with line word0 = 0xDEADBEEF_CAFEF00D.
REQ-023 Five back-to-back loads with Latency 4 and QueueDepth 4.
- Expected: the fifth is acked only in the cycle the first returns.
- Expected: returns occur on consecutive cycles with tids in order.
REQ-024 AMO_ADD size 010 at 0x80 with old 0xFFFFFFFF and data 1.
- Expected: ATOMIC_ACK data 0xFFFFFFFF; the location then holds 0x00000000.
REQ-025 Store size 011 at offset 0x4 -> STORE_ACK returned, memory unchanged, err_o=1 until reset.
REQ-026 Assert rst_i with 3 requests in flight -> no rtrn_vld_o afterwards; a later load returns pre-reset store data.

Source files
------------

// File: rtl/config_pkg.sv
// Core-configuration subset consumed by the D$ memory responder.
// Only the fields the responder cross-checks against its cache packages are present.
package config_pkg;

   typedef struct packed {
      int unsigned XLEN;
      int unsigned DCACHE_LINE_WIDTH;
   } cva6_cfg_t;

   localparam cva6_cfg_t cva6_cfg_empty = '{XLEN: 64, DCACHE_LINE_WIDTH: 128};

endpackage

// File: rtl/wt_cache_pkg.sv
// Write-through D$ types shared by the cache and its memory-side models.
// Also holds the byte-mask and AMO helpers used by the memory responder.
package wt_cache_pkg;

   localparam int unsigned XLEN                = 64;
   localparam int unsigned DCACHE_LINE_WIDTH   = 128;
   localparam int unsigned DCACHE_LINE_BYTES   = DCACHE_LINE_WIDTH / 8;
   localparam int unsigned DCACHE_OFFSET_WIDTH = $clog2(DCACHE_LINE_BYTES);
   localparam int unsigned PADDR_WIDTH         = 32;
   localparam int unsigned CACHE_ID_WIDTH      = 4;
   localparam int unsigned DCACHE_USER_WIDTH   = 8;

   typedef enum logic [1:0] {
      DCACHE_LOAD_REQ   = 2'd0,
      DCACHE_STORE_REQ  = 2'd1,
      DCACHE_ATOMIC_REQ = 2'd2
   } dcache_out_t;

   typedef enum logic [1:0] {
      DCACHE_LOAD_ACK   = 2'd0,
      DCACHE_STORE_ACK  = 2'd1,
      DCACHE_INV_REQ    = 2'd2,
      DCACHE_ATOMIC_ACK = 2'd3
   } dcache_in_t;

   typedef enum logic [3:0] {
      AMO_NONE = 4'h0,
      AMO_LR   = 4'h1,
      AMO_SC   = 4'h2,
      AMO_SWAP = 4'h3,
      AMO_ADD  = 4'h4,
      AMO_AND  = 4'h5,
      AMO_OR   = 4'h6,
      AMO_XOR  = 4'h7
   } amo_t;

   typedef struct packed {
      logic       vld;
      logic       all;
      logic [7:0] idx;
      logic [1:0] way;
   } cache_inval_t;

   typedef struct packed {
      dcache_out_t                rtype;
      logic [2:0]                 size;
      logic [PADDR_WIDTH-1:0]     paddr;
      logic [XLEN-1:0]            data;
      logic                       nc;
      logic [CACHE_ID_WIDTH-1:0]  tid;
      amo_t                       amo_op;
   } dcache_req_t;

   typedef struct packed {
      dcache_in_t                   rtype;
      logic [DCACHE_LINE_WIDTH-1:0] data;
      logic [DCACHE_USER_WIDTH-1:0] user;
      cache_inval_t                 inv;
      logic [CACHE_ID_WIDTH-1:0]    tid;
   } dcache_rtrn_t;

   typedef struct packed {
      logic [XLEN-1:0] wdata;
      logic [XLEN-1:0] rdata;
      logic            wr;
      logic            err;
   } amo_res_t;

   // Zero mask means the size/offset pair is illegal (too wide or misaligned).
   function automatic logic [DCACHE_LINE_BYTES-1:0] size_to_be(
      input logic [2:0]                     size,
      input logic [DCACHE_OFFSET_WIDTH-1:0] off
   );
      logic [DCACHE_LINE_BYTES-1:0] ones;
      logic                         aligned;
      ones    = '0;
      aligned = 1'b0;
      case (size)
         3'b000: begin ones = DCACHE_LINE_BYTES'(8'h01); aligned = 1'b1;            end
         3'b001: begin ones = DCACHE_LINE_BYTES'(8'h03); aligned = (off[0] == 1'b0);   end
         3'b010: begin ones = DCACHE_LINE_BYTES'(8'h0F); aligned = (off[1:0] == 2'b0); end
         3'b011: begin ones = DCACHE_LINE_BYTES'(8'hFF); aligned = (off[2:0] == 3'b0); end
         default: ;
      endcase
      return aligned ? (ones << off) : '0;
   endfunction

   // Lanes arrive already shifted down to bit 0; results are masked to the operand width.
   function automatic amo_res_t amo_compute(
      input amo_t            op,
      input logic [2:0]      size,
      input logic [XLEN-1:0] old_lane,
      input logic [XLEN-1:0] opnd_lane
   );
      amo_res_t        res;
      logic [XLEN-1:0] mask;
      logic [XLEN-1:0] old_v;
      logic [XLEN-1:0] opnd_v;
      mask      = (size == 3'b010) ? XLEN'(32'hFFFF_FFFF) : '1;
      old_v     = old_lane & mask;
      opnd_v    = opnd_lane & mask;
      res.rdata = old_v;
      res.wdata = '0;
      res.wr    = 1'b0;
      res.err   = 1'b0;
      if (size != 3'b010 && size != 3'b011) begin
         res.err = 1'b1;
      end else begin
         case (op)
            AMO_SWAP: begin res.wdata = opnd_v; res.wr = 1'b1; end
            AMO_ADD:  begin res.wdata = (old_v + opnd_v) & mask; res.wr = 1'b1; end
            AMO_LR:   ;
            AMO_SC:   begin res.wdata = opnd_v; res.wr = 1'b1; res.rdata = '0; end
            default:  res.err = 1'b1;
         endcase
      end
      return res;
   endfunction

endpackage

// File: rtl/wt_dcache_mem_responder_pkg.sv
// Local types and helpers of the D$ memory responder.
package wt_dcache_mem_responder_pkg;

   localparam int unsigned LatCntW = 4;

   typedef wt_cache_pkg::dcache_req_t  mem_req_t;
   typedef wt_cache_pkg::dcache_rtrn_t mem_rtrn_t;

   // Byte i of the line takes byte (i mod XLEN/8) of the lane word where be[i] is set.
   function automatic logic [wt_cache_pkg::DCACHE_LINE_WIDTH-1:0] merge_line(
      input logic [wt_cache_pkg::DCACHE_LINE_WIDTH-1:0] line,
      input logic [wt_cache_pkg::DCACHE_LINE_BYTES-1:0] be,
      input logic [wt_cache_pkg::XLEN-1:0]              lanes
   );
      logic [wt_cache_pkg::DCACHE_LINE_WIDTH-1:0] res;
      res = line;
      for (int i = 0; i < int'(wt_cache_pkg::DCACHE_LINE_BYTES); i++) begin
         if (be[i]) res[i*8 +: 8] = lanes[(i % int'(wt_cache_pkg::XLEN / 8))*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/wt_mem_resp_queue.sv
// In-order return queue: each entry carries a latency countdown; the head leaves when it hits 0.
module wt_mem_resp_queue
   import wt_dcache_mem_responder_pkg::*;
#(
   parameter int unsigned Latency    = 4,
   parameter int unsigned QueueDepth = 4
) (
   input  logic      i_clk,
   input  logic      i_rst,
   input  logic      i_push,
   input  mem_rtrn_t i_entry,
   output logic      o_full,
   output logic      o_pop,
   output mem_rtrn_t o_head
);

   localparam int unsigned PtrW = $clog2(QueueDepth);
   localparam int unsigned CntW = $clog2(QueueDepth + 1);
   localparam logic [LatCntW-1:0] LatInit = LatCntW'(Latency - 1);

   mem_rtrn_t          r_data [QueueDepth];
   logic [LatCntW-1:0] r_lat  [QueueDepth];
   logic [PtrW-1:0]    r_wptr;
   logic [PtrW-1:0]    r_rptr;
   logic [CntW-1:0]    r_count;
   logic               w_pop;

   assign w_pop  = (r_count != '0) && (r_lat[r_rptr] == '0);
   assign o_pop  = w_pop;
   assign o_full = (r_count == CntW'(QueueDepth));
   assign o_head = r_data[r_rptr];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         for (int i = 0; i < int'(QueueDepth); i++) r_lat[i] <= '0;
      end else begin
         for (int i = 0; i < int'(QueueDepth); i++) begin
            if (r_lat[i] != '0) r_lat[i] <= r_lat[i] - 1'b1;
         end
         // The load of a newly pushed slot overrides its decrement above.
         if (i_push) begin
            r_lat[r_wptr] <= LatInit;
            r_wptr        <= r_wptr + 1'b1;
         end
         if (w_pop) r_rptr <= r_rptr + 1'b1;
         case ({i_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_push) r_data[r_wptr] <= i_entry;
   end

endmodule

// File: rtl/wt_dcache_mem_responder.sv
// Behavioural memory behind the write-through D$: the backing store is accessed at accept time,
// and responses are released in order after a fixed minimum latency.
module wt_dcache_mem_responder
   import wt_dcache_mem_responder_pkg::*;
#(
   parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
   parameter type dcache_req_t              = logic,
   parameter type dcache_rtrn_t             = logic,
   parameter int unsigned Latency           = 4,
   parameter int unsigned QueueDepth        = 4,
   parameter int unsigned MemLines          = 256
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         data_req_i,
   output logic         data_ack_o,
   input  dcache_req_t  data_i,
   output logic         rtrn_vld_o,
   output dcache_rtrn_t rtrn_o,
   output logic         err_o
);

   localparam int unsigned IdxW      = $clog2(MemLines);
   localparam int unsigned OffW      = wt_cache_pkg::DCACHE_OFFSET_WIDTH;
   localparam int unsigned LineW     = wt_cache_pkg::DCACHE_LINE_WIDTH;
   localparam int unsigned LineBytes = wt_cache_pkg::DCACHE_LINE_BYTES;
   localparam int unsigned XlenW     = wt_cache_pkg::XLEN;

   if (Latency < 1 || Latency > 15 || QueueDepth < 2 || (QueueDepth & (QueueDepth - 1)) != 0 ||
       MemLines < 2 || (MemLines & (MemLines - 1)) != 0 ||
       OffW + IdxW > wt_cache_pkg::PADDR_WIDTH || CVA6Cfg.XLEN != XlenW ||
       CVA6Cfg.DCACHE_LINE_WIDTH != LineW) begin : g_bad_params
      $fatal(1, "wt_dcache_mem_responder: illegal parameterisation");
   end

   mem_req_t                w_req;
   mem_rtrn_t               w_rtrn_in;
   mem_rtrn_t               w_head;
   mem_rtrn_t               w_rtrn_out;
   logic [LineW-1:0]        r_mem [MemLines];
   logic [IdxW-1:0]         w_idx;
   logic [OffW-1:0]         w_off;
   logic [5:0]              w_sh;
   logic [LineW-1:0]        w_line;
   logic [LineW-1:0]        w_wline;
   logic [XlenW-1:0]        w_word;
   logic [LineBytes-1:0]    w_be;
   wt_cache_pkg::amo_res_t  w_amo;
   logic                    w_full;
   logic                    w_pop;
   logic                    w_ack;
   logic                    w_keep;
   logic                    w_wr;
   logic                    w_err_set;
   logic                    r_err;
   logic                    w_unused;

   assign w_req    = mem_req_t'(data_i);
   assign w_idx    = w_req.paddr[OffW +: IdxW];
   assign w_off    = w_req.paddr[OffW-1:0];
   assign w_sh     = {w_off[2:0], 3'b000};
   assign w_line   = r_mem[w_idx];
   assign w_word   = w_line[w_off[OffW-1:3]*XlenW +: XlenW];
   assign w_be     = wt_cache_pkg::size_to_be(w_req.size, w_off);
   assign w_amo    = wt_cache_pkg::amo_compute(w_req.amo_op, w_req.size, w_word >> w_sh,
                                               w_req.data >> w_sh);
   assign w_unused = ^{w_req.nc, w_req.paddr};

   always_comb begin
      w_rtrn_in     = '0;
      w_rtrn_in.tid = w_req.tid;
      w_wline       = merge_line(w_line, w_be, w_req.data);
      w_wr          = 1'b0;
      w_err_set     = 1'b0;
      w_keep        = 1'b1;
      case (w_req.rtype)
         wt_cache_pkg::DCACHE_LOAD_REQ: begin
            w_rtrn_in.rtype = wt_cache_pkg::DCACHE_LOAD_ACK;
            w_rtrn_in.data  = w_line;
         end
         wt_cache_pkg::DCACHE_STORE_REQ: begin
            w_rtrn_in.rtype = wt_cache_pkg::DCACHE_STORE_ACK;
            w_wr            = (w_be != '0);
            w_err_set       = (w_be == '0);
         end
         wt_cache_pkg::DCACHE_ATOMIC_REQ: begin
            w_rtrn_in.rtype = wt_cache_pkg::DCACHE_ATOMIC_ACK;
            w_rtrn_in.data  = LineW'(w_amo.rdata);
            w_wline         = merge_line(w_line, w_be, w_amo.wdata << w_sh);
            w_wr            = w_amo.wr && (w_be != '0);
            w_err_set       = w_amo.err || (w_be == '0);
         end
         default: begin
            w_keep    = 1'b0;
            w_err_set = 1'b1;
         end
      endcase
   end

   assign w_ack = data_req_i && !rst_i && (!w_full || w_pop);

   wt_mem_resp_queue #(
      .Latency    (Latency),
      .QueueDepth (QueueDepth)
   ) u_queue (
      .i_clk   (clk_i),
      .i_rst   (rst_i),
      .i_push  (w_ack && w_keep),
      .i_entry (w_rtrn_in),
      .o_full  (w_full),
      .o_pop   (w_pop),
      .o_head  (w_head)
   );

   // Backing store is deliberately outside reset so contents survive it.
   always_ff @(posedge clk_i) begin
      if (w_ack && w_wr) r_mem[w_idx] <= w_wline;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_err <= 1'b0;
      end else if (w_ack && w_err_set) begin
         r_err <= 1'b1;
      end
   end

   assign w_rtrn_out = (w_pop && !rst_i) ? w_head : '0;
   assign data_ack_o = w_ack;
   assign rtrn_vld_o = w_pop && !rst_i;
   assign rtrn_o     = dcache_rtrn_t'(w_rtrn_out);
   assign err_o      = r_err && !rst_i;

endmodule

// File: tb/tb_wt_dcache_mem_responder.sv
// Directed bench for the D$ memory responder: latency, ordering, store/AMO semantics, errors, reset.
module tb_wt_dcache_mem_responder;
   import wt_cache_pkg::*;

   localparam int unsigned Lat = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         data_req;
   logic         data_ack;
   dcache_req_t  data;
   logic         rtrn_vld;
   dcache_rtrn_t rtrn;
   logic         err;
   int           checks = 0;
   int           errors = 0;

   always #5 clk = ~clk;

   wt_dcache_mem_responder #(
      .CVA6Cfg       (config_pkg::cva6_cfg_empty),
      .dcache_req_t  (dcache_req_t),
      .dcache_rtrn_t (dcache_rtrn_t),
      .Latency       (Lat),
      .QueueDepth    (4),
      .MemLines      (256)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .data_req_i (data_req),
      .data_ack_o (data_ack),
      .data_i     (data),
      .rtrn_vld_o (rtrn_vld),
      .rtrn_o     (rtrn),
      .err_o      (err)
   );

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic dcache_req_t mk(input dcache_out_t rt, input logic [2:0] size,
                                      input logic [31:0] paddr, input logic [63:0] d,
                                      input logic [3:0] tid, input amo_t op);
      dcache_req_t r;
      r        = '0;
      r.rtype  = rt;
      r.size   = size;
      r.paddr  = paddr;
      r.data   = d;
      r.tid    = tid;
      r.amo_op = op;
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input string tag, input dcache_req_t r);
      data     = r;
      data_req = 1'b1;
      @(negedge clk);
      chk({tag, " ack"}, 160'(data_ack), 160'(1));
      tick();
      data_req = 1'b0;
      data     = '0;
   endtask

   task automatic await(input string tag, output int lat, output dcache_rtrn_t rt);
      lat = 1;
      @(negedge clk);
      while (!rtrn_vld && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      rt = rtrn;
      chk({tag, " vld"}, 160'(rtrn_vld), 160'(1));
      tick();
   endtask

   task automatic xact(input string tag, input dcache_req_t r, input dcache_in_t exp_type,
                       input logic [127:0] exp_data);
      int           lat;
      dcache_rtrn_t rt;
      send(tag, r);
      await(tag, lat, rt);
      chk({tag, " latency"}, 160'(lat), 160'(Lat));
      chk({tag, " rtype"}, 160'(rt.rtype), 160'(exp_type));
      chk({tag, " tid"}, 160'(rt.tid), 160'(r.tid));
      chk({tag, " data"}, 160'(rt.data), 160'(exp_data));
      chk({tag, " inv/user"}, 160'({rt.inv, rt.user}), 160'(0));
   endtask

   task automatic quiet(input string tag, input int cycles);
      int seen;
      seen = 0;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         if (rtrn_vld) seen++;
      end
      chk(tag, 160'(seen), 160'(0));
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned line40_lo;
      rst      = 1'b1;
      data_req = 1'b1;
      data     = mk(DCACHE_LOAD_REQ, 3'd3, 32'h40, '0, 4'd1, AMO_NONE);
      tick();
      tick();
      @(negedge clk);
      chk("reset ack", 160'(data_ack), 160'(0));
      chk("reset vld", 160'(rtrn_vld), 160'(0));
      chk("reset rtrn", 160'(rtrn), 160'(0));
      chk("reset err", 160'(err), 160'(0));
      tick();
      rst      = 1'b0;
      data_req = 1'b0;
      data     = '0;
      tick();

      // Store then load to the same line.
      xact("st 0x48", mk(DCACHE_STORE_REQ, 3'd3, 32'h48, 64'h11223344_55667788, 4'd2, AMO_NONE),
           DCACHE_STORE_ACK, '0);
      xact("st 0x40", mk(DCACHE_STORE_REQ, 3'd3, 32'h40, 64'hDEADBEEF_CAFEF00D, 4'd3, AMO_NONE),
           DCACHE_STORE_ACK, '0);
      xact("ld 0x40", mk(DCACHE_LOAD_REQ, 3'd0, 32'h40, '0, 4'd5, AMO_NONE), DCACHE_LOAD_ACK,
           {64'h11223344_55667788, 64'hDEADBEEF_CAFEF00D});
      xact("st byte 0x45", mk(DCACHE_STORE_REQ, 3'd0, 32'h45, 64'h0000AB00_00000000, 4'd6,
           AMO_NONE), DCACHE_STORE_ACK, '0);
      xact("ld after byte", mk(DCACHE_LOAD_REQ, 3'd3, 32'h40, '0, 4'd7, AMO_NONE),
           DCACHE_LOAD_ACK, {64'h11223344_55667788, 64'hDEADABEF_CAFEF00D});
      chk("err clean", 160'(err), 160'(0));

      // Five back-to-back loads into a four-deep queue.
      data_req = 1'b1;
      for (int k = 0; k < 4; k++) begin
         data = mk(DCACHE_LOAD_REQ, 3'd3, 32'h40, '0, 4'(k + 1), AMO_NONE);
         @(negedge clk);
         chk("b2b ack", 160'(data_ack), 160'(1));
         chk("b2b early vld", 160'(rtrn_vld), 160'(0));
         tick();
      end
      data = mk(DCACHE_LOAD_REQ, 3'd3, 32'h40, '0, 4'd5, AMO_NONE);
      @(negedge clk);
      chk("fifth ack on first return", 160'(data_ack), 160'(1));
      chk("first return vld", 160'(rtrn_vld), 160'(1));
      chk("first return tid", 160'(rtrn.tid), 160'(1));
      tick();
      data_req = 1'b0;
      data     = '0;
      for (int k = 2; k <= 5; k++) begin
         @(negedge clk);
         chk("b2b vld", 160'(rtrn_vld), 160'(1));
         chk("b2b tid", 160'(rtrn.tid), 160'(k));
         tick();
      end
      @(negedge clk);
      chk("b2b drained", 160'(rtrn_vld), 160'(0));
      tick();

      // AMO sequence on the word at 0x80.
      xact("st 0x80", mk(DCACHE_STORE_REQ, 3'd3, 32'h80, 64'h12345678_FFFFFFFF, 4'd8, AMO_NONE),
           DCACHE_STORE_ACK, '0);
      xact("amo add", mk(DCACHE_ATOMIC_REQ, 3'd2, 32'h80, 64'd1, 4'd9, AMO_ADD),
           DCACHE_ATOMIC_ACK, 128'hFFFFFFFF);
      xact("ld after add", mk(DCACHE_LOAD_REQ, 3'd3, 32'h80, '0, 4'd10, AMO_NONE),
           DCACHE_LOAD_ACK, {64'h0, 64'h12345678_00000000});
      xact("amo sc", mk(DCACHE_ATOMIC_REQ, 3'd2, 32'h80, 64'hA5A5A5A5, 4'd11, AMO_SC),
           DCACHE_ATOMIC_ACK, '0);
      xact("amo lr w", mk(DCACHE_ATOMIC_REQ, 3'd2, 32'h80, '0, 4'd12, AMO_LR),
           DCACHE_ATOMIC_ACK, 128'hA5A5A5A5);
      xact("amo swap d", mk(DCACHE_ATOMIC_REQ, 3'd3, 32'h80, 64'h01020304_05060708, 4'd13,
           AMO_SWAP), DCACHE_ATOMIC_ACK, 128'h12345678_A5A5A5A5);
      xact("amo lr d", mk(DCACHE_ATOMIC_REQ, 3'd3, 32'h80, '0, 4'd14, AMO_LR),
           DCACHE_ATOMIC_ACK, 128'h01020304_05060708);
      chk("err after amo", 160'(err), 160'(0));

      // Misaligned store: acked, ignored, sticky error.
      xact("st misaligned", mk(DCACHE_STORE_REQ, 3'd3, 32'h44, '1, 4'd15, AMO_NONE),
           DCACHE_STORE_ACK, '0);
      chk("err misaligned", 160'(err), 160'(1));
      xact("ld unchanged", mk(DCACHE_LOAD_REQ, 3'd3, 32'h40, '0, 4'd1, AMO_NONE),
           DCACHE_LOAD_ACK, {64'h11223344_55667788, 64'hDEADABEF_CAFEF00D});
      chk("err sticky", 160'(err), 160'(1));

      // Reset with three loads in flight.
      data_req = 1'b1;
      for (int k = 0; k < 3; k++) begin
         data = mk(DCACHE_LOAD_REQ, 3'd3, 32'h40, '0, 4'(k + 7), AMO_NONE);
         @(negedge clk);
         chk("inflight ack", 160'(data_ack), 160'(1));
         tick();
      end
      data_req = 1'b0;
      data     = '0;
      rst      = 1'b1;
      @(negedge clk);
      chk("mid reset vld", 160'(rtrn_vld), 160'(0));
      tick();
      tick();
      rst = 1'b0;
      quiet("no return after reset", 8);
      chk("err cleared", 160'(err), 160'(0));
      line40_lo = 32'hCAFEF00D;
      xact("ld post reset", mk(DCACHE_LOAD_REQ, 3'd3, 32'h40, '0, 4'd4, AMO_NONE),
           DCACHE_LOAD_ACK, {64'h11223344_55667788, 32'hDEADABEF, line40_lo});

      // Unknown rtype is swallowed and flags an error.
      send("unknown rtype", mk(dcache_out_t'(2'd3), 3'd3, 32'h40, '0, 4'd2, AMO_NONE));
      quiet("unknown rtype no return", 8);
      chk("err unknown rtype", 160'(err), 160'(1));

      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      chk("err cleared again", 160'(err), 160'(0));
      xact("amo and", mk(DCACHE_ATOMIC_REQ, 3'd3, 32'h80, 64'hF, 4'd3, AMO_AND),
           DCACHE_ATOMIC_ACK, 128'h01020304_05060708);
      chk("err bad amo", 160'(err), 160'(1));
      xact("lr after bad amo", mk(DCACHE_ATOMIC_REQ, 3'd3, 32'h80, '0, 4'd6, AMO_LR),
           DCACHE_ATOMIC_ACK, 128'h01020304_05060708);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
